// File: rtl/bigseg_table_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : bigseg_table_arbiter_if
// Brief    : Lookup, update and clear handshake bundle for the big-segment table.
// Revision : 1.0
// ============================================================================
interface bigseg_table_arbiter_if #(
  parameter int IDX_W = 8
);
  logic             lk_valid;
  logic             lk_ready;
  logic [IDX_W-1:0] lk_seg_index;
  logic             lk_rsp_valid;
  logic [59:0]      lk_rsp_entry;
  logic             lk_rsp_err;
  logic             up_valid;
  logic             up_ready;
  logic [IDX_W-1:0] up_seg_index;
  logic [2:0]       up_group;
  logic [10:0]      up_index;
  logic             up_big;
  logic             up_done;
  logic             up_err;
  logic             clr_start;
  logic             busy;
  logic             clr_done;

  modport master (
    output lk_valid, lk_seg_index, up_valid, up_seg_index, up_group, up_index, up_big, clr_start,
    input  lk_ready, lk_rsp_valid, lk_rsp_entry, lk_rsp_err, up_ready, up_done, up_err, busy, clr_done
  );

  modport slave (
    input  lk_valid, lk_seg_index, up_valid, up_seg_index, up_group, up_index, up_big, clr_start,
    output lk_ready, lk_rsp_valid, lk_rsp_entry, lk_rsp_err, up_ready, up_done, up_err, busy, clr_done
  );
endinterface
`default_nettype wire

// File: rtl/bigseg_table_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : bigseg_table_arbiter
// Brief    : Big-segment table with lookup/update arbitration and bulk clear.
// Revision : 1.0
// ============================================================================
module bigseg_table_arbiter #(
  parameter int SEG_NUM    = 184,
  parameter int IDX_W      = 8,
  parameter int STARVE_MAX = 4
) (
  input logic                   clk,
  input logic                   rst_n,
  bigseg_table_arbiter_if.slave bus
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] UP_RD = 2'd1;
  localparam logic [1:0] UP_WR = 2'd2;
  localparam logic [1:0] CLR   = 2'd3;

  localparam int              c_SW         = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [c_SW-1:0] c_STARVE_MAX = c_SW'(STARVE_MAX);
  localparam logic [IDX_W:0]  c_SEG_NUM    = (IDX_W + 1)'(SEG_NUM);
  localparam logic [IDX_W-1:0] c_LAST_SEG  = IDX_W'(SEG_NUM - 1);

  logic [59:0]      r_table [SEG_NUM];
  logic [1:0]       r_state;
  logic [c_SW-1:0]  r_starve;
  logic [IDX_W-1:0] r_clr_cnt;
  logic             r_clr_pend;
  logic [IDX_W-1:0] r_up_seg;
  logic [2:0]       r_up_group;
  logic [10:0]      r_up_index;
  logic             r_up_big;
  logic             r_up_bad;
  logic [59:0]      r_rd_entry;
  logic             r_lk_rsp_valid;
  logic [59:0]      r_lk_rsp_entry;
  logic             r_lk_rsp_err;

  logic             w_idle_free;
  logic             w_up_grant;
  logic             w_lk_grant;
  logic             w_lk_in_range;
  logic             w_up_bad;
  logic [59:0]      w_merged;
  logic             w_wr_en;
  logic [IDX_W-1:0] w_wr_addr;
  logic [59:0]      w_wr_data;

  assign w_idle_free   = (r_state == IDLE) && !r_clr_pend;
  assign w_up_grant    = w_idle_free && bus.up_valid && ((r_starve == c_STARVE_MAX) || !bus.lk_valid);
  assign w_lk_grant    = w_idle_free && bus.lk_valid && !w_up_grant;
  assign w_lk_in_range = {1'b0, bus.lk_seg_index} < c_SEG_NUM;
  assign w_up_bad      = ({1'b0, bus.up_seg_index} >= c_SEG_NUM) || (bus.up_group > 3'd4);

  assign bus.lk_ready     = w_lk_grant;
  assign bus.up_ready     = w_up_grant;
  assign bus.lk_rsp_valid = r_lk_rsp_valid;
  assign bus.lk_rsp_entry = r_lk_rsp_entry;
  assign bus.lk_rsp_err   = r_lk_rsp_err;
  assign bus.up_done      = (r_state == UP_WR);
  assign bus.up_err       = (r_state == UP_WR) && r_up_bad;
  assign bus.clr_done     = (r_state == CLR) && (r_clr_cnt == c_LAST_SEG);
  assign bus.busy         = (r_state != IDLE);

  // Group g lives at [59-12g -: 12] as {index[10:0], big}.
  always_comb begin
    w_merged = r_rd_entry;
    for (int g = 0; g < 5; g++) begin
      if (r_up_group == 3'(g)) begin
        w_merged[59-12*g -: 12] = {r_up_index, r_up_big};
      end
    end
  end

  always_comb begin
    w_wr_en   = 1'b0;
    w_wr_addr = r_up_seg;
    w_wr_data = w_merged;
    if ((r_state == UP_WR) && !r_up_bad) begin
      w_wr_en = 1'b1;
    end else if (r_state == CLR) begin
      w_wr_en   = 1'b1;
      w_wr_addr = r_clr_cnt;
      w_wr_data = '0;
    end
  end

  // Table contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_table[w_wr_addr] <= w_wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= IDLE;
      r_starve       <= '0;
      r_clr_cnt      <= '0;
      r_clr_pend     <= 1'b0;
      r_up_seg       <= '0;
      r_up_group     <= '0;
      r_up_index     <= '0;
      r_up_big       <= 1'b0;
      r_up_bad       <= 1'b0;
      r_rd_entry     <= '0;
      r_lk_rsp_valid <= 1'b0;
      r_lk_rsp_entry <= '0;
      r_lk_rsp_err   <= 1'b0;
    end else begin
      r_lk_rsp_valid <= w_lk_grant;
      r_lk_rsp_err   <= w_lk_grant && !w_lk_in_range;
      if (w_lk_grant) begin
        r_lk_rsp_entry <= w_lk_in_range ? r_table[bus.lk_seg_index] : '0;
      end

      if (!bus.up_valid || w_up_grant) begin
        r_starve <= '0;
      end else if (w_lk_grant && (r_starve != c_STARVE_MAX)) begin
        r_starve <= r_starve + 1'b1;
      end

      // A request arriving mid-clear is dropped; otherwise it waits for IDLE.
      if (r_state == CLR) begin
        if (r_clr_cnt == c_LAST_SEG) begin
          r_clr_pend <= 1'b0;
        end
      end else if (bus.clr_start) begin
        r_clr_pend <= 1'b1;
      end

      case (r_state)
        IDLE: begin
          if (r_clr_pend) begin
            r_state   <= CLR;
            r_clr_cnt <= '0;
          end else if (w_up_grant) begin
            r_state    <= UP_RD;
            r_up_seg   <= bus.up_seg_index;
            r_up_group <= bus.up_group;
            r_up_index <= bus.up_index;
            r_up_big   <= bus.up_big;
            r_up_bad   <= w_up_bad;
          end
        end
        UP_RD: begin
          r_rd_entry <= r_up_bad ? '0 : r_table[r_up_seg];
          r_state    <= UP_WR;
        end
        UP_WR: begin
          r_state <= IDLE;
        end
        CLR: begin
          if (r_clr_cnt == c_LAST_SEG) begin
            r_state <= IDLE;
          end else begin
            r_clr_cnt <= r_clr_cnt + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_bigseg_table_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_bigseg_table_arbiter
// Brief    : Scoreboard bench for bigseg_table_arbiter against an array model.
// Revision : 1.0
// ============================================================================
module tb_bigseg_table_arbiter;
  localparam int SEG_NUM    = 184;
  localparam int IDX_W      = 8;
  localparam int STARVE_MAX = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bigseg_table_arbiter_if #(.IDX_W(IDX_W)) bus ();

  bigseg_table_arbiter #(
    .SEG_NUM    (SEG_NUM),
    .IDX_W      (IDX_W),
    .STARVE_MAX (STARVE_MAX)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [59:0] entry;
    logic        err;
    int          due;
  } lk_exp_t;

  lk_exp_t     lk_q[$];
  lk_exp_t     e_tmp;
  logic [59:0] model [SEG_NUM];
  int          n_checks = 0;
  int          n_fails  = 0;
  int          cyc      = 0;
  bit          pend_valid = 0;
  int          pend_due, pend_seg, pend_grp;
  logic [10:0] pend_idx;
  logic        pend_big;
  bit          pend_err;
  bit          clr_req  = 0;
  bit          clr_arm  = 0;
  int          clr_exp  = -1;
  int          busy_run = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: outputs and handshakes sampled on the falling edge.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      check("reset_flags", {bus.lk_rsp_valid, bus.lk_rsp_err, bus.up_done, bus.up_err,
                            bus.clr_done, bus.busy}, 64'd0);
      check("reset_entry", bus.lk_rsp_entry, 64'd0);
      lk_q.delete();
      pend_valid = 0;
      clr_req    = 0;
      busy_run   = 0;
    end else begin
      if (lk_q.size() > 0 && lk_q[0].due == cyc) begin
        check("lk_rsp_valid", bus.lk_rsp_valid, 1);
        check("lk_rsp_entry", bus.lk_rsp_entry, lk_q[0].entry);
        check("lk_rsp_err", bus.lk_rsp_err, lk_q[0].err);
        void'(lk_q.pop_front());
      end else if (bus.lk_rsp_valid) begin
        check("lk_rsp_spurious", bus.lk_rsp_valid, 0);
      end

      if (pend_valid && pend_due == cyc) begin
        check("up_done", bus.up_done, 1);
        check("up_err", bus.up_err, pend_err);
        if (!pend_err) model[pend_seg][59-12*pend_grp -: 12] = {pend_idx, pend_big};
        pend_valid = 0;
      end else if (bus.up_done) begin
        check("up_done_spurious", bus.up_done, 0);
      end

      if (bus.busy) busy_run++;
      else busy_run = 0;
      if (bus.clr_done) check("clr_cycles_in_clr", busy_run, SEG_NUM);
      if (clr_exp >= 0 && cyc == clr_exp) begin
        check("clr_done_timing", bus.clr_done, 1);
        clr_exp = -1;
      end

      if (bus.lk_ready || bus.up_ready) check("grant_exclusive", bus.lk_ready & bus.up_ready, 0);

      if (bus.lk_valid && bus.lk_ready) begin
        e_tmp.err = int'(bus.lk_seg_index) >= SEG_NUM;
        if (e_tmp.err) e_tmp.entry = '0;
        else e_tmp.entry = model[bus.lk_seg_index];
        e_tmp.due = cyc + 1;
        lk_q.push_back(e_tmp);
      end
      if (bus.up_valid && bus.up_ready) begin
        pend_valid = 1;
        pend_due   = cyc + 2;
        pend_seg   = int'(bus.up_seg_index);
        pend_grp   = int'(bus.up_group);
        pend_idx   = bus.up_index;
        pend_big   = bus.up_big;
        pend_err   = (pend_seg >= SEG_NUM) || (pend_grp > 4);
      end
      if (bus.clr_start) begin
        clr_req = 1;
        if (clr_arm) begin
          clr_exp = cyc + SEG_NUM + 1;
          clr_arm = 0;
        end
      end
      // An accepted update lands before the clear wipes the table.
      if (clr_req && !pend_valid) begin
        foreach (model[i]) model[i] = '0;
        clr_req = 0;
      end
    end
  end

  task automatic do_lookup(input int idx);
    int n = 0;
    bus.lk_valid     = 1'b1;
    bus.lk_seg_index = IDX_W'(idx);
    @(negedge clk);
    while (!bus.lk_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!bus.lk_ready) check("lk_grant_timeout", bus.lk_ready, 1);
    @(posedge clk); #1;
    bus.lk_valid = 1'b0;
  endtask

  task automatic do_update(input int seg, input int grp, input logic [10:0] idx, input logic big);
    int n = 0;
    bus.up_valid     = 1'b1;
    bus.up_seg_index = IDX_W'(seg);
    bus.up_group     = 3'(grp);
    bus.up_index     = idx;
    bus.up_big       = big;
    @(negedge clk);
    while (!bus.up_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!bus.up_ready) check("up_grant_timeout", bus.up_ready, 1);
    @(posedge clk); #1;
    bus.up_valid = 1'b0;
  endtask

  task automatic pulse_clr(input bit arm);
    clr_arm       = arm;
    bus.clr_start = 1'b1;
    @(posedge clk); #1;
    bus.clr_start = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic starve_test();
    int  lk_cnt = 0;
    int  rounds = 0;
    int  n      = 0;
    bit  up_acc;
    bus.lk_valid     = 1'b1;
    bus.up_valid     = 1'b1;
    bus.lk_seg_index = IDX_W'($urandom_range(0, SEG_NUM - 1));
    bus.up_seg_index = IDX_W'($urandom_range(0, SEG_NUM - 1));
    bus.up_group     = 3'($urandom_range(0, 4));
    bus.up_index     = 11'($urandom);
    bus.up_big       = 1'($urandom);
    while (rounds < 3 && n < 200) begin
      @(negedge clk);
      n++;
      up_acc = bus.up_ready;
      if (bus.lk_ready) lk_cnt++;
      if (up_acc) begin
        check("starve_lk_grants", lk_cnt, STARVE_MAX);
        lk_cnt = 0;
        rounds++;
      end
      @(posedge clk); #1;
      bus.lk_seg_index = IDX_W'($urandom_range(0, SEG_NUM - 1));
      if (up_acc) begin
        bus.up_seg_index = IDX_W'($urandom_range(0, SEG_NUM - 1));
        bus.up_group     = 3'($urandom_range(0, 4));
        bus.up_index     = 11'($urandom);
        bus.up_big       = 1'($urandom);
      end
    end
    if (rounds < 3) check("starve_rounds_timeout", rounds, 3);
    bus.lk_valid = 1'b0;
    bus.up_valid = 1'b0;
  endtask

  initial begin
    bus.lk_valid = 0; bus.lk_seg_index = '0;
    bus.up_valid = 0; bus.up_seg_index = '0; bus.up_group = '0;
    bus.up_index = '0; bus.up_big = 0; bus.clr_start = 0;
    foreach (model[i]) model[i] = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    idle_cycles(1);

    // Clear, then read back first, middle and last entries.
    pulse_clr(1);
    idle_cycles(SEG_NUM + 4);
    do_lookup(0);
    do_lookup(100);
    do_lookup(SEG_NUM - 1);

    // Group 2 rewrite of seg 5 with neighbours populated.
    do_update(5, 0, 11'h123, 1'b0);
    do_update(5, 4, 11'h5A5, 1'b1);
    do_update(5, 2, 11'h3A5, 1'b1);
    do_lookup(5);
    check("seg5_group2_bits", bus.lk_rsp_entry[35:24], {11'h3A5, 1'b1});

    // Rejected updates and out-of-range lookup.
    do_update(3, 1, 11'h0F0, 1'b1);
    do_update(200, 1, 11'h7FF, 1'b1);
    do_update(3, 6, 11'h7FF, 1'b1);
    do_lookup(190);
    do_lookup(3);
    do_lookup(5);

    starve_test();
    idle_cycles(5);

    // Reset while the update is in UP_RD.
    do_update(7, 1, 11'h155, 1'b0);
    idle_cycles(3);
    do_update(7, 3, 11'h7FF, 1'b1);
    rst_n = 1'b0;
    #1;
    check("reset_busy", bus.busy, 0);
    check("reset_up_done", bus.up_done, 0);
    idle_cycles(2);
    rst_n = 1'b1;
    idle_cycles(1);
    do_lookup(7);

    // Clear requested while the update is in UP_WR.
    do_update(9, 0, 11'h2AB, 1'b1);
    idle_cycles(1);
    pulse_clr(1);
    idle_cycles(SEG_NUM + 6);
    do_lookup(9);
    do_lookup(5);

    for (int i = 0; i < 800; i++) begin
      bus.lk_valid     = ($urandom_range(0, 99) < 60);
      bus.lk_seg_index = ($urandom_range(0, 9) == 0) ? IDX_W'($urandom_range(SEG_NUM, 255))
                                                     : IDX_W'($urandom_range(0, SEG_NUM - 1));
      bus.up_valid     = ($urandom_range(0, 99) < 30);
      bus.up_seg_index = ($urandom_range(0, 9) == 0) ? IDX_W'($urandom_range(SEG_NUM, 255))
                                                     : IDX_W'($urandom_range(0, SEG_NUM - 1));
      bus.up_group     = 3'($urandom_range(0, 5));
      bus.up_index     = 11'($urandom);
      bus.up_big       = 1'($urandom);
      bus.clr_start    = ($urandom_range(0, 399) == 0);
      @(posedge clk); #1;
    end
    bus.lk_valid  = 0;
    bus.up_valid  = 0;
    bus.clr_start = 0;
    idle_cycles(SEG_NUM + 10);
    for (int i = 0; i < 4; i++) do_lookup($urandom_range(0, SEG_NUM - 1));
    idle_cycles(4);

    check("lk_queue_drained", lk_q.size(), 0);
    check("up_pending_drained", pend_valid, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
`default_nettype wire
